// File: rtl/adc_servo_filter.sv
// adc_servo_filter: averages strobed 12-bit ADC frames, applies a deadband to
// the averaged value, then slew-limits it into an 8-bit servo position word.
module adc_servo_filter #(
    parameter int AVG_LOG2   = 3,
    parameter int MAX_STEP   = 4,
    parameter int UPDATE_DIV = 500000,
    parameter int DEADBAND   = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [7:0]  avg_out,
    output logic [7:0]  pos_out,
    output logic        pos_valid,
    output logic        frame_err
);

    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int TICK_W = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UPDATE_DIV - 1);
    localparam logic [7:0]        STEP_MAX  = 8'(MAX_STEP);
    localparam logic [8:0]        DB_MIN    = 9'(DEADBAND);
    localparam logic [7:0]        CENTRE    = 8'h80;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    // Registered state
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [7:0]          r_avg;
    logic [7:0]          r_target;
    logic [7:0]          r_pos;
    logic                r_pos_valid;
    logic                r_frame_err;
    state_t              r_state;

    // Combinational helpers
    logic                w_bad_frame;
    logic                w_accept;
    logic                w_last;
    logic [ACC_W-1:0]    w_sum;
    logic [7:0]          w_avg8;
    logic [8:0]          w_db_diff;
    logic [8:0]          w_db_abs;
    logic                w_db_hit;
    logic                w_tick;
    logic [7:0]          w_gap;
    logic [7:0]          w_step;
    logic [7:0]          w_target_nxt;
    logic [7:0]          w_pos_nxt;
    logic                w_move;
    state_t              w_state_nxt;

    assign w_bad_frame = sample_valid && (sample_in[15:12] != 4'h0);
    assign w_accept    = sample_valid && (sample_in[15:12] == 4'h0);
    assign w_last      = w_accept && (r_cnt == '1);
    assign w_sum       = r_acc + ACC_W'(sample_in[11:0]);
    // Top 8 bits of the window sum are bits [11:4] of the truncated mean.
    assign w_avg8      = w_sum[ACC_W-1 -: 8];
    assign w_db_diff   = {1'b0, w_avg8} - {1'b0, r_target};
    assign w_db_abs    = w_db_diff[8] ? (9'd0 - w_db_diff) : w_db_diff;
    assign w_db_hit    = (w_db_abs >= DB_MIN);
    assign w_tick      = (r_tick_cnt == TICK_LAST);

    // Next target, slew step and next FSM state; the step always uses the
    // target held before this edge so a same-cycle target update waits a tick.
    // State is derived from the values being loaded, so r_state always
    // matches r_target vs r_pos.
    always_comb begin
        w_target_nxt = r_target;
        w_pos_nxt    = r_pos;
        w_move       = 1'b0;
        w_gap        = '0;
        w_step       = '0;
        w_state_nxt  = HOLD;

        if (w_last && w_db_hit) begin
            w_target_nxt = w_avg8;
        end

        case (r_state)
            UP: begin
                w_gap  = r_target - r_pos;
                w_step = (w_gap > STEP_MAX) ? STEP_MAX : w_gap;
                if (w_tick) begin
                    w_pos_nxt = r_pos + w_step;
                    w_move    = 1'b1;
                end
            end
            DOWN: begin
                w_gap  = r_pos - r_target;
                w_step = (w_gap > STEP_MAX) ? STEP_MAX : w_gap;
                if (w_tick) begin
                    w_pos_nxt = r_pos - w_step;
                    w_move    = 1'b1;
                end
            end
            default: begin
                w_pos_nxt = r_pos;
            end
        endcase

        if (w_pos_nxt < w_target_nxt) begin
            w_state_nxt = UP;
        end else if (w_pos_nxt > w_target_nxt) begin
            w_state_nxt = DOWN;
        end else begin
            w_state_nxt = HOLD;
        end
    end

    // Sample accumulation; window closes on the last accepted sample.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Average and deadbanded target register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_avg    <= '0;
            r_target <= CENTRE;
        end else begin
            if (w_last) begin
                r_avg <= w_avg8;
            end
            r_target <= w_target_nxt;
        end
    end

    // Free-running slew tick divider.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // FSM state register and slew-limited position.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= HOLD;
            r_pos       <= CENTRE;
            r_pos_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_pos_valid <= w_move;
        end
    end

    // One-cycle frame error flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad_frame;
        end
    end

    assign avg_out   = r_avg;
    assign pos_out   = r_pos;
    assign pos_valid = r_pos_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_adc_servo_filter.sv
// Directed testbench for adc_servo_filter with a short slew tick divider.
module tb_adc_servo_filter;

    logic        Clk;
    logic        Rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [7:0]  avg_out;
    logic [7:0]  pos_out;
    logic        pos_valid;
    logic        frame_err;

    int n_checks;
    int n_fail;

    adc_servo_filter #(
        .AVG_LOG2  (3),
        .MAX_STEP  (4),
        .UPDATE_DIV(10),
        .DEADBAND  (2)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .avg_out     (avg_out),
        .pos_out     (pos_out),
        .pos_valid   (pos_valid),
        .frame_err   (frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one strobed frame, starting at a falling edge.
    task automatic strobe(input logic [15:0] d);
        @(negedge Clk);
        sample_in    = d;
        sample_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge Clk);
        sample_in    = 16'h0000;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        #2 Rst = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        sample_in = 16'h0000;
        sample_valid = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (pos_out !== 8'h80) begin n_fail++; $display("FAIL reset_pos: got %h want 80", pos_out); end
        n_checks++;
        if (avg_out !== 8'h00) begin n_fail++; $display("FAIL reset_avg: got %h want 00", avg_out); end
        n_checks++;
        if (pos_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got pv=%b fe=%b want 0 0", pos_valid, frame_err);
        end
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_slew_up();
        int exp_pos;
        int pulses;
        for (int i = 0; i < 8; i++) strobe(16'h0FF0);
        idle();
        n_checks++;
        if (avg_out !== 8'hFF) begin n_fail++; $display("FAIL up_avg: got %h want ff", avg_out); end
        exp_pos = 8'h80;
        pulses = 0;
        for (int c = 0; c < 400; c++) begin
            if (pos_valid === 1'b1) begin
                pulses++;
                exp_pos = (exp_pos + 4 > 255) ? 255 : exp_pos + 4;
            end
            n_checks++;
            if (pos_out !== exp_pos[7:0]) begin
                n_fail++; $display("FAIL up_pos cycle %0d: got %h want %h", c, pos_out, exp_pos[7:0]);
            end
            @(negedge Clk);
        end
        n_checks++;
        if (pulses != 32) begin n_fail++; $display("FAIL up_pulses: got %0d want 32", pulses); end
        n_checks++;
        if (pos_out !== 8'hFF) begin n_fail++; $display("FAIL up_final: got %h want ff", pos_out); end
    endtask

    task automatic test_slew_down();
        int exp_pos;
        int pulses;
        for (int i = 0; i < 8; i++) strobe(16'(i * 16'h0100));
        idle();
        n_checks++;
        if (avg_out !== 8'h38) begin n_fail++; $display("FAIL down_avg: got %h want 38", avg_out); end
        exp_pos = 8'hFF;
        pulses = 0;
        for (int c = 0; c < 600; c++) begin
            if (pos_valid === 1'b1) begin
                pulses++;
                exp_pos = (exp_pos - 4 < 8'h38) ? 8'h38 : exp_pos - 4;
            end
            n_checks++;
            if (pos_out !== exp_pos[7:0]) begin
                n_fail++; $display("FAIL down_pos cycle %0d: got %h want %h", c, pos_out, exp_pos[7:0]);
            end
            @(negedge Clk);
        end
        n_checks++;
        if (pulses != 50) begin n_fail++; $display("FAIL down_pulses: got %0d want 50", pulses); end
    endtask

    task automatic test_reset_midrun();
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        n_checks++;
        if (pos_out !== 8'h80) begin n_fail++; $display("FAIL async_pos: got %h want 80", pos_out); end
        n_checks++;
        if (avg_out !== 8'h00) begin n_fail++; $display("FAIL async_avg: got %h want 00", avg_out); end
        n_checks++;
        if (pos_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL async_flags: got pv=%b fe=%b want 0 0", pos_valid, frame_err);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_deadband();
        int pulses;
        for (int i = 0; i < 8; i++) strobe(16'h0810);
        idle();
        n_checks++;
        if (avg_out !== 8'h81) begin n_fail++; $display("FAIL db_avg: got %h want 81", avg_out); end
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            if (pos_valid === 1'b1) pulses++;
            @(negedge Clk);
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL db_pulses: got %0d want 0", pulses); end
        n_checks++;
        if (pos_out !== 8'h80) begin n_fail++; $display("FAIL db_pos: got %h want 80", pos_out); end
    endtask

    task automatic test_frame_err();
        strobe(16'h0400);
        strobe(16'h0400);
        strobe(16'h0400);
        strobe(16'h1ABC);
        strobe(16'h0400);
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
        strobe(16'h0400);
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
        strobe(16'h0400);
        strobe(16'h0400);
        idle();
        n_checks++;
        if (avg_out !== 8'h81) begin n_fail++; $display("FAIL ferr_early_avg: got %h want 81", avg_out); end
        strobe(16'h0400);
        idle();
        n_checks++;
        if (avg_out !== 8'h40) begin n_fail++; $display("FAIL ferr_avg: got %h want 40", avg_out); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_idle: got %b want 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) strobe(16'h0FFF);
        idle();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            strobe(16'h0400);
            if (i == 7) begin
                n_checks++;
                if (avg_out !== 8'h00) begin
                    n_fail++; $display("FAIL b2b_early_avg: got %h want 00", avg_out);
                end
            end
        end
        idle();
        n_checks++;
        if (avg_out !== 8'h40) begin n_fail++; $display("FAIL b2b_avg: got %h want 40", avg_out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_slew_up();
        test_slew_down();
        n_checks++;
        if (pos_out !== 8'h38) begin n_fail++; $display("FAIL pre_reset_pos: got %h want 38", pos_out); end
        test_reset_midrun();
        test_deadband();
        test_frame_err();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
